// File: rtl/io_uart_rx_param.sv
// io_uart_rx_param: UART receiver with 3-sample mid-bit majority voting, valid/ready word hold,
// per-word parity/frame flags and overrun pulse. Optional rx_break output via UART_RX_BREAK_DETECT_EN.
module io_uart_rx_param #(
  parameter int CLOCK_FREQ  = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 TXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                 rx_break,
`endif
  output logic                 rx_busy
);

  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
  localparam int MID        = BIT_PERIOD / 2;
  localparam int CW         = $clog2(BIT_PERIOD + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MIDM1 = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(MID);
  localparam logic [CW-1:0] CNT_MIDP1 = CW'(MID + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] ST_ARM    = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
    $error("io_uart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
    $error("io_uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_par
    $error("io_uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (BIT_PERIOD < 8) begin : g_err_bp
    $error("io_uart_rx_param: BIT_PERIOD must be at least 8");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("io_uart_rx_param: SYNC_STAGES must be at least 2");
  end

  function automatic logic maj3_f(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Odd parity wants data^parity == 1, even wants 0; a return of 1 flags a mismatch.
  function automatic logic parity_err_f(input logic [DATA_BITS-1:0] d, input logic p);
    if (PARITY == 1) begin
      return ~(^d ^ p);
    end else begin
      return ^d ^ p;
    end
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             votes_q, votes_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, data_q, data_d;
  logic                   perr_flag_q, perr_flag_d, ferr_flag_q, ferr_flag_d;
  logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                   ovr_q, ovr_d, busy_q, busy_d;
  logic                   s_s, in_frame_s, sample_now_s, bit_s;
  logic                   last_stop_s, frame_bad_s, is_break_s, deliver_s;

  assign s_s          = sync_q[SYNC_STAGES-1];
  assign in_frame_s   = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign sample_now_s = in_frame_s && (cnt_q == CNT_MIDP1);
  assign bit_s        = maj3_f(votes_q[0], votes_q[1], s_s);
  assign last_stop_s  = sample_now_s && (state_q == ST_STOP) && (bit_idx_q == STOP_LAST);
  assign frame_bad_s  = ferr_flag_q | ~bit_s;
  assign deliver_s    = last_stop_s && !is_break_s;

`ifdef UART_RX_BREAK_DETECT_EN
  logic zero_q, zero_d, brk_q;

  // Track whether every data, parity and stop sample of the frame has been 0.
  always_comb begin
    zero_d = zero_q;
    if (sample_now_s && state_q == ST_START) begin
      zero_d = 1'b1;
    end else if (sample_now_s) begin
      zero_d = zero_q & ~bit_s;
    end else begin
      zero_d = zero_q;
    end
  end

  assign is_break_s = last_stop_s & zero_q & ~bit_s;
  assign rx_break   = brk_q;

  // Break tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      brk_q  <= is_break_s;
    end
  end
`else
  assign is_break_s = 1'b0;
`endif

  // Frame sequencing; bit timer restarts every BIT_PERIOD from the start-edge cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    votes_d     = votes_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    perr_flag_d = perr_flag_q;
    ferr_flag_d = ferr_flag_q;
    busy_d      = busy_q;
    if (in_frame_s) begin
      cnt_d = (cnt_q == CNT_LAST) ? {CW{1'b0}} : cnt_q + CNT_ONE;
      if (cnt_q == CNT_MIDM1) begin
        votes_d[0] = s_s;
      end else if (cnt_q == CNT_MID) begin
        votes_d[1] = s_s;
      end else begin
        votes_d = votes_q;
      end
    end else begin
      votes_d = votes_q;
    end
    case (state_q)
      ST_ARM: begin
        if (!s_s) begin
          cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = {CW{1'b0}};
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (!s_s && s_prev_q) begin
          state_d = ST_START;
          cnt_d   = CNT_ONE;
          busy_d  = 1'b1;
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      ST_START: begin
        if (sample_now_s && bit_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (sample_now_s) begin
          state_d     = ST_DATA;
          bit_idx_d   = 4'd0;
          perr_flag_d = 1'b0;
          ferr_flag_d = 1'b0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_now_s) begin
          if (MSB_FIRST != 0) begin
            shift_d = {shift_q[DATA_BITS-2:0], bit_s};
          end else begin
            shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
          end
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = 4'd0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (sample_now_s) begin
          perr_flag_d = parity_err_f(shift_q, bit_s);
          state_d     = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (last_stop_s) begin
          ferr_flag_d = frame_bad_s;
          bit_idx_d   = 4'd0;
          cnt_d       = {CW{1'b0}};
          busy_d      = 1'b0;
          state_d     = (frame_bad_s || is_break_s) ? ST_ARM : ST_IDLE;
        end else if (sample_now_s) begin
          ferr_flag_d = frame_bad_s;
          bit_idx_d   = bit_idx_q + 4'd1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  // Output word hold: a handshake on the delivery cycle frees the slot for the new word.
  always_comb begin
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = 1'b0;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (deliver_s && (!valid_q || rx_ready)) begin
      data_d  = shift_q;
      perr_d  = perr_flag_q;
      ferr_d  = frame_bad_s;
      valid_d = 1'b1;
    end else if (deliver_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = 1'b0;
    end
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{1'b1}};
      s_prev_q    <= 1'b1;
      state_q     <= ST_ARM;
      cnt_q       <= {CW{1'b0}};
      votes_q     <= 2'b00;
      bit_idx_q   <= 4'd0;
      shift_q     <= {DATA_BITS{1'b0}};
      perr_flag_q <= 1'b0;
      ferr_flag_q <= 1'b0;
      data_q      <= {DATA_BITS{1'b0}};
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], TXD};
      s_prev_q    <= s_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      votes_q     <= votes_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      perr_flag_q <= perr_flag_d;
      ferr_flag_q <= ferr_flag_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_io_uart_rx_param.sv
// Directed bench for io_uart_rx_param: three instances (LSB-first, MSB-first, even parity)
// at BIT_PERIOD=10, frames driven bit-by-bit on negedges, results recorded per cycle.
`timescale 1ns/1ps
module tb_io_uart_rx_param;

  localparam int BP = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic line;
  int   lane;
  logic ready;
  logic txd_a, txd_p;

  wire [2:0] vld, perr, ferr, ovr, busy;
  wire [7:0] dat0, dat1, dat2;
`ifdef UART_RX_BREAK_DETECT_EN
  wire [2:0] brk;
`endif

  int n_chk = 0;
  int n_err = 0;

  int         cyc;
  int         first_t [3];
  logic [7:0] cap_dat [3];
  logic       cap_perr [3];
  logic       cap_ferr [3];
  int         vcnt [3];
  int         ocnt [3];
  logic       busy_hi [3];

  always #5 clk = ~clk;

  assign txd_a = (lane == 0) ? line : 1'b1;
  assign txd_p = (lane == 1) ? line : 1'b1;

  io_uart_rx_param #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_lsb (
    .clk(clk), .rst_n(rst_n), .TXD(txd_a), .rx_data(dat0), .rx_valid(vld[0]),
    .rx_ready(ready), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_overrun(ovr[0]),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk[0]),
`endif
    .rx_busy(busy[0]));

  io_uart_rx_param #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_msb (
    .clk(clk), .rst_n(rst_n), .TXD(txd_a), .rx_data(dat1), .rx_valid(vld[1]),
    .rx_ready(ready), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_overrun(ovr[1]),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk[1]),
`endif
    .rx_busy(busy[1]));

  io_uart_rx_param #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_par (
    .clk(clk), .rst_n(rst_n), .TXD(txd_p), .rx_data(dat2), .rx_valid(vld[2]),
    .rx_ready(ready), .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_overrun(ovr[2]),
`ifdef UART_RX_BREAK_DETECT_EN
    .rx_break(brk[2]),
`endif
    .rx_busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dat_of(input int k);
    if (k == 0) return dat0;
    else if (k == 1) return dat1;
    else return dat2;
  endfunction

  task automatic clear_rec();
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      first_t[k] = -1; cap_dat[k] = 8'h00; cap_perr[k] = 1'b0; cap_ferr[k] = 1'b0;
      vcnt[k] = 0; ocnt[k] = 0; busy_hi[k] = 1'b0;
    end
  endtask

  // One cycle: sample outputs at negedge (state after previous posedge), then drive the line.
  task automatic tick(input logic v);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (vld[k]) begin
        vcnt[k]++;
        if (first_t[k] < 0) begin
          first_t[k]  = cyc - 1;
          cap_dat[k]  = dat_of(k);
          cap_perr[k] = perr[k];
          cap_ferr[k] = ferr[k];
        end
      end
      if (ovr[k]) ocnt[k]++;
      if (busy[k]) busy_hi[k] = 1'b1;
    end
    cyc++;
    line = v;
  endtask

  // Drive start, 8 data bits LSB-first, parity bit (lane 1 only) and one stop bit.
  task automatic send_frame(input logic [7:0] b, input int ln, input logic par_bit,
                            input logic stop_bit, input int tail, input int rst_at);
    int         nbits;
    logic [10:0] bits;
    nbits = (ln == 1) ? 11 : 10;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    if (ln == 1) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
    end else begin
      bits[9] = stop_bit;
    end
    lane = ln;
    clear_rec();
    for (int t = 0; t < nbits * BP + tail; t++) begin
      tick((t < nbits * BP) ? bits[t / BP] : 1'b1);
      if (t == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {29'd0, vld}, 32'd0);
        chk("midrst_busy", {29'd0, busy}, 32'd0);
        chk("midrst_data", {24'd0, dat0}, 32'd0);
        chk("midrst_flags", {26'd0, ovr, ferr}, 32'd0);
      end else if (t == rst_at + 3) begin
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; line = 1'b1; lane = 0; ready = 1'b1;
    clear_rec();
    repeat (3) @(negedge clk);
    chk("reset_valid", {29'd0, vld}, 32'd0);
    chk("reset_busy", {29'd0, busy}, 32'd0);
    chk("reset_ovr_ferr_perr", {23'd0, ovr, ferr, perr}, 32'd0);
    chk("reset_data", {dat2, dat1, dat0}, 32'd0);
    rst_n = 1'b1;
    repeat (20) tick(1'b1);

    // 0xA5 on both 8N1 instances; palindrome under bit reversal.
    send_frame(8'hA5, 0, 1'b0, 1'b1, 20, -1);
    chk("a5_latency", first_t[0], 32'd98);
    chk("a5_data_lsb", cap_dat[0], 32'hA5);
    chk("a5_errs", {cap_perr[0], cap_ferr[0]}, 32'd0);
    chk("a5_valid_cycles", vcnt[0], 32'd1);
    chk("a5_data_msb", cap_dat[1], 32'hA5);
    chk("a5_busy_end", {29'd0, busy}, 32'd0);

    send_frame(8'h01, 0, 1'b0, 1'b1, 20, -1);
    chk("x01_data_lsb", cap_dat[0], 32'h01);
    chk("x01_data_msb", cap_dat[1], 32'h80);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right.
    send_frame(8'h03, 1, 1'b1, 1'b1, 20, -1);
    chk("par_bad_latency", first_t[2], 32'd108);
    chk("par_bad_data", cap_dat[2], 32'h03);
    chk("par_bad_perr", cap_perr[2], 32'd1);
    chk("par_bad_ferr", cap_ferr[2], 32'd0);
    chk("par_other_lane_quiet", vcnt[0], 32'd0);
    send_frame(8'h03, 1, 1'b0, 1'b1, 20, -1);
    chk("par_ok_perr", cap_perr[2], 32'd0);
    chk("par_ok_data", cap_dat[2], 32'h03);

    // Low stop bit, then a start after only 5 idle cycles must be ignored.
    send_frame(8'h55, 0, 1'b0, 1'b0, 0, -1);
    chk("ferr_data", cap_dat[0], 32'h55);
    chk("ferr_flag", cap_ferr[0], 32'd1);
    chk("ferr_perr", cap_perr[0], 32'd0);
    repeat (5) tick(1'b1);
    send_frame(8'h00, 0, 1'b0, 1'b1, 30, -1);
    chk("arm_ignores_start", vcnt[0] + vcnt[1], 32'd0);
    send_frame(8'h3C, 0, 1'b0, 1'b1, 20, -1);
    chk("after_arm_data", cap_dat[0], 32'h3C);
    chk("after_arm_ferr", cap_ferr[0], 32'd0);

    // Overrun: second word discarded while the first is held.
    ready = 1'b0;
    send_frame(8'h11, 0, 1'b0, 1'b1, 20, -1);
    chk("ovr_first_data", cap_dat[0], 32'h11);
    send_frame(8'h22, 0, 1'b0, 1'b1, 20, -1);
    chk("ovr_pulses", ocnt[0], 32'd1);
    chk("ovr_held_data", {24'd0, dat0}, 32'h11);
    chk("ovr_held_msb", {24'd0, dat1}, 32'h88);
    chk("ovr_held_valid", {31'd0, vld[0]}, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    chk("handshake_drop", {31'd0, vld[0]}, 32'd0);

    // Short glitch: false start, no word.
    clear_rec();
    for (int t = 0; t < 40; t++) tick((t < 3) ? 1'b0 : 1'b1);
    chk("glitch_busy_rose", busy_hi[0], 32'd1);
    chk("glitch_no_valid", vcnt[0], 32'd0);
    chk("glitch_busy_end", {31'd0, busy[0]}, 32'd0);

    // Reset mid-frame with a word held; the remainder of the frame must not deliver.
    ready = 1'b0;
    send_frame(8'h5A, 0, 1'b0, 1'b1, 20, -1);
    chk("pre_rst_valid", {31'd0, vld[0]}, 32'd1);
    send_frame(8'h00, 0, 1'b0, 1'b1, 40, 45);
    chk("post_rst_no_valid", {29'd0, vld}, 32'd0);
    chk("post_rst_no_ovr", ocnt[0], 32'd0);
    ready = 1'b1;
    send_frame(8'h96, 0, 1'b0, 1'b1, 20, -1);
    chk("post_rst_latency", first_t[0], 32'd98);
    chk("post_rst_data_lsb", cap_dat[0], 32'h96);
    chk("post_rst_data_msb", cap_dat[1], 32'h69);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
